// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues IMEM requests under a credit
// limit, and pairs in-order responses with their PC/prediction in a queue toward decode.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4,
  parameter int          MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_inst,
  output logic        fetch_req_valid,
  output logic        fetch_req_ready,
  output logic [31:0] fetch_addr,
  input  logic [31:0] bpu_next_pc,
  input  logic        bpu_jump,
  input  logic        mispredict,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_inst,
  output logic        dec_pred_taken
);

  localparam int FQ_AW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int MO_AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  // Wide enough to hold fq_cnt + meta_cnt and meta_cnt + drop_cnt without wrapping.
  localparam int CW = $clog2(FQ_DEPTH + MAX_OUT + 1);
  localparam logic [CW-1:0]    FQ_LIM  = CW'(FQ_DEPTH);
  localparam logic [CW-1:0]    MO_LIM  = CW'(MAX_OUT);
  localparam logic [MO_AW-1:0] MO_LAST = MO_AW'(MAX_OUT - 1);

  logic [31:0]      r_pc;
  logic [31:0]      r_meta_pc   [MAX_OUT];
  logic             r_meta_pred [MAX_OUT];
  logic [MO_AW-1:0] r_meta_rd;
  logic [MO_AW-1:0] r_meta_wr;
  logic [CW-1:0]    r_meta_cnt;
  logic [CW-1:0]    r_drop_cnt;
  logic [31:0]      r_fq_pc     [FQ_DEPTH];
  logic [31:0]      r_fq_inst   [FQ_DEPTH];
  logic             r_fq_pred   [FQ_DEPTH];
  logic [FQ_AW-1:0] r_fq_rd;
  logic [FQ_AW-1:0] r_fq_wr;
  logic [CW-1:0]    r_fq_cnt;

  logic          w_req_valid;
  logic          w_accept;
  logic          w_resp_use;
  logic          w_resp_drop;
  logic          w_push;
  logic          w_pop;
  logic          w_dec_valid;
  logic [CW-1:0] w_flush_sub;
  logic [CW-1:0] w_drop_flush;

  function automatic logic [MO_AW-1:0] meta_inc(input logic [MO_AW-1:0] p);
    if (p == MO_LAST) return '0;
    else              return p + MO_AW'(1);
  endfunction

  assign w_req_valid = !rst && !mispredict
                       && ((r_fq_cnt + r_meta_cnt) < FQ_LIM)
                       && ((r_meta_cnt + r_drop_cnt) < MO_LIM);
  assign w_accept    = w_req_valid && imem_req_ready;
  // Responses owed to a flushed path are consumed before any live one.
  assign w_resp_drop = imem_resp_valid && (r_drop_cnt != '0);
  assign w_resp_use  = imem_resp_valid && (r_drop_cnt == '0) && (r_meta_cnt != '0);
  assign w_push      = w_resp_use && !mispredict && !rst;
  assign w_dec_valid = (r_fq_cnt != '0) && !mispredict && !rst;
  assign w_pop       = w_dec_valid && dec_ready;

  // A response arriving in the flush cycle retires one owed response itself.
  assign w_flush_sub  = {{(CW-1){1'b0}},
                         imem_resp_valid && ((r_drop_cnt != '0) || (r_meta_cnt != '0))};
  assign w_drop_flush = r_drop_cnt + r_meta_cnt - w_flush_sub;

  assign imem_req_valid  = w_req_valid;
  assign imem_req_addr   = r_pc;
  assign fetch_req_valid = w_req_valid;
  assign fetch_req_ready = imem_req_ready;
  assign fetch_addr      = r_pc;
  assign dec_valid       = w_dec_valid;
  assign dec_pc          = r_fq_pc[r_fq_rd];
  assign dec_inst        = r_fq_inst[r_fq_rd];
  assign dec_pred_taken  = r_fq_pred[r_fq_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_meta_rd  <= '0;
      r_meta_wr  <= '0;
      r_meta_cnt <= '0;
      r_drop_cnt <= '0;
      r_fq_rd    <= '0;
      r_fq_wr    <= '0;
      r_fq_cnt   <= '0;
    end else if (mispredict) begin
      r_pc       <= bpu_next_pc;
      r_meta_rd  <= '0;
      r_meta_wr  <= '0;
      r_meta_cnt <= '0;
      r_drop_cnt <= w_drop_flush;
      r_fq_rd    <= '0;
      r_fq_wr    <= '0;
      r_fq_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_pc      <= bpu_next_pc;
        r_meta_wr <= meta_inc(r_meta_wr);
      end
      if (w_resp_use) r_meta_rd <= meta_inc(r_meta_rd);
      if (w_resp_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
      if (w_push) r_fq_wr <= r_fq_wr + FQ_AW'(1);
      if (w_pop) r_fq_rd <= r_fq_rd + FQ_AW'(1);

      case ({w_accept, w_resp_use})
        2'b10:   r_meta_cnt <= r_meta_cnt + CW'(1);
        2'b01:   r_meta_cnt <= r_meta_cnt - CW'(1);
        default: r_meta_cnt <= r_meta_cnt;
      endcase

      case ({w_push, w_pop})
        2'b10:   r_fq_cnt <= r_fq_cnt + CW'(1);
        2'b01:   r_fq_cnt <= r_fq_cnt - CW'(1);
        default: r_fq_cnt <= r_fq_cnt;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_meta_pc[r_meta_wr]   <= r_pc;
      r_meta_pred[r_meta_wr] <= bpu_jump;
    end
    if (w_push) begin
      r_fq_pc[r_fq_wr]   <= r_meta_pc[r_meta_rd];
      r_fq_inst[r_fq_wr] <= imem_resp_inst;
      r_fq_pred[r_fq_wr] <= r_meta_pred[r_meta_rd];
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: bench-owned IMEM/BPU environment plus a transaction-level
// model (pending fetches and in-flight IMEM requests) that predicts every output.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int FQ_DEPTH = 4;
  localparam int MAX_OUT  = 2;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_inst;
  logic        fetch_req_valid;
  logic        fetch_req_ready;
  logic [31:0] fetch_addr;
  logic [31:0] bpu_next_pc;
  logic        bpu_jump;
  logic        mispredict;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst;
  logic        dec_pred_taken;

  if_fetch_unit #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_inst(imem_resp_inst), .fetch_req_valid(fetch_req_valid),
    .fetch_req_ready(fetch_req_ready), .fetch_addr(fetch_addr),
    .bpu_next_pc(bpu_next_pc), .bpu_jump(bpu_jump), .mispredict(mispredict),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
    .dec_inst(dec_inst), .dec_pred_taken(dec_pred_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A fetch accepted and not yet flushed or handed to decode.
  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic        arrived;
    logic [31:0] inst;
  } pend_t;
  // A request held by the IMEM; dead once its path is flushed.
  typedef struct {
    logic [31:0] addr;
    int          due;
    logic        live;
  } flight_t;

  pend_t   pend_q[$];
  flight_t imem_q[$];
  logic [31:0] m_pc;
  int n_chk, n_fail, cyc, acc_cnt;
  int lat_lo, lat_hi, rdy_pct, dec_pct, rsp_pct;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic jump_of(input logic [31:0] a);
    return (a == 32'h0000_0008) || (a[6:2] == 5'd13);
  endfunction

  function automatic logic [31:0] next_of(input logic [31:0] a);
    if (a == 32'h0000_0008) return 32'h0000_0100;
    if (a[6:2] == 5'd13)    return (a + 32'h0000_0240) & 32'h0000_FFFC;
    return a + 32'h0000_0004;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, check outputs, then advance the model.
  task automatic step(input logic r, input logic m, input logic [31:0] tgt);
    logic resp, exp_rv, exp_dv;
    int k;
    @(negedge clk);
    rst = r;
    mispredict = m;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    dec_ready = ($urandom_range(99) < dec_pct);
    resp = !r && (imem_q.size() > 0) && (imem_q[0].due <= cyc) && ($urandom_range(99) < rsp_pct);
    imem_resp_valid = resp;
    imem_resp_inst = resp ? inst_of(imem_q[0].addr) : $urandom;
    bpu_next_pc = m ? tgt : next_of(m_pc);
    bpu_jump = m ? 1'b0 : jump_of(m_pc);
    #1;
    exp_rv = !r && !m && (pend_q.size() < FQ_DEPTH) && (imem_q.size() < MAX_OUT);
    exp_dv = !r && !m && (pend_q.size() > 0) && pend_q[0].arrived;
    chk("imem_req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
    chk("fetch_req_valid", {31'd0, fetch_req_valid}, {31'd0, exp_rv});
    chk("fetch_req_ready", {31'd0, fetch_req_ready}, {31'd0, imem_req_ready});
    chk("dec_valid", {31'd0, dec_valid}, {31'd0, exp_dv});
    if (!r) begin
      chk("imem_req_addr", imem_req_addr, m_pc);
      chk("fetch_addr", fetch_addr, m_pc);
    end
    if (exp_dv) begin
      chk("dec_pc", dec_pc, pend_q[0].pc);
      chk("dec_inst", dec_inst, pend_q[0].inst);
      chk("dec_pred_taken", {31'd0, dec_pred_taken}, {31'd0, pend_q[0].pred});
    end
    if (imem_req_valid && imem_req_ready) acc_cnt++;

    if (r) begin
      pend_q.delete();
      imem_q.delete();
      m_pc = RESET_PC;
    end else if (m) begin
      pend_q.delete();
      foreach (imem_q[i]) imem_q[i].live = 1'b0;
      if (resp) void'(imem_q.pop_front());
      m_pc = tgt;
    end else begin
      if (exp_dv && dec_ready) void'(pend_q.pop_front());
      if (resp) begin
        if (imem_q[0].live) begin
          k = 0;
          while (k < pend_q.size() && pend_q[k].arrived) k++;
          if (k < pend_q.size()) begin
            pend_q[k].arrived = 1'b1;
            pend_q[k].inst = inst_of(imem_q[0].addr);
          end
        end
        void'(imem_q.pop_front());
      end
      if (exp_rv && imem_req_ready) begin
        pend_q.push_back('{pc: m_pc, pred: jump_of(m_pc), arrived: 1'b0, inst: 32'h0});
        imem_q.push_back('{addr: m_pc, due: cyc + $urandom_range(lat_hi, lat_lo), live: 1'b1});
        m_pc = next_of(m_pc);
      end
    end
    cyc++;
  endtask

  task automatic set_env(input int lo, input int hi, input int rdy, input int dec, input int rsp);
    lat_lo = lo; lat_hi = hi; rdy_pct = rdy; dec_pct = dec; rsp_pct = rsp;
  endtask

  initial begin
    int base;
    logic seen;
    n_chk = 0; n_fail = 0; cyc = 0; acc_cnt = 0;
    m_pc = RESET_PC;
    rst = 1'b1; mispredict = 1'b0; imem_req_ready = 1'b0; dec_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_inst = 32'h0; bpu_next_pc = 32'h0; bpu_jump = 1'b0;

    set_env(1, 1, 100, 100, 100);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);

    // Straight-line fetch with one-cycle IMEM; 0x8 predicts taken to 0x100.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'h0);

    // Drain, then stall decode: the credit must admit exactly FQ_DEPTH fetches.
    set_env(1, 1, 0, 100, 100);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
    set_env(1, 1, 100, 0, 100);
    base = acc_cnt;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0);
    chk("stall_accepts", acc_cnt - base, 32'd4);
    chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    set_env(1, 1, 100, 100, 100);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0);

    // Flush with two requests outstanding, then with one responding in the flush cycle.
    set_env(3, 3, 100, 100, 100);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0200);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (dec_valid) begin
        seen = 1'b1;
        chk("first_pc_after_flush", dec_pc, 32'h0000_0200);
      end
    end
    if (!seen) chk("flush_refill_timeout", 32'd0, 32'd1);
    set_env(2, 2, 100, 100, 100);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0400);
    step(1'b0, 1'b1, 32'h0000_0500);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);

    // Randomized traffic with flushes and occasional mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0)
        set_env(1, $urandom_range(4, 1), $urandom_range(100, 40),
                $urandom_range(100, 20), $urandom_range(100, 50));
      step(($urandom_range(999) < 3), ($urandom_range(99) < 6), $urandom & 32'h0000_FFFC);
    end

    // Fill the queue, then reset with work in flight.
    set_env(2, 2, 100, 0, 100);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("post_reset_addr", imem_req_addr, RESET_PC);
    chk("post_reset_dec_valid", {31'd0, dec_valid}, 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
